// File: rtl/mem_port_arbiter.sv
`default_nettype none
// =============================================================================
// mem_port_arbiter - fetch/data arbiter for one shared single-port RAM  (rev 1.0)
// =============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int STREAK_W = $clog2(STARVE_MAX + 1);
  localparam logic [STREAK_W-1:0] C_STREAK_MAX = STREAK_W'(STARVE_MAX);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_BUSY_IF = 3'd1;
  localparam logic [2:0] S_BUSY_D  = 3'd2;
  localparam logic [2:0] S_RESP_IF = 3'd3;
  localparam logic [2:0] S_RESP_D  = 3'd4;

  logic [2:0]          r_state;
  logic [2:0]          w_next;
  logic [STREAK_W-1:0] r_streak;
  logic                w_grant_d;
  logic                w_grant_if;

  // Data wins ties unless fetch has already lost STARVE_MAX times in a row.
  always_comb begin
    w_grant_d  = d_req && !(if_req && (r_streak == C_STREAK_MAX));
    w_grant_if = if_req && !w_grant_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          w_next = S_BUSY_D;
        end else if (w_grant_if) begin
          w_next = S_BUSY_IF;
        end
      end
      S_BUSY_IF: if (mem_ready) w_next = S_RESP_IF;
      S_BUSY_D:  if (mem_ready) w_next = S_RESP_D;
      S_RESP_IF: w_next = S_IDLE;
      S_RESP_D:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req = (r_state == S_BUSY_IF) || (r_state == S_BUSY_D);
    if_ack  = (r_state == S_RESP_IF);
    d_ack   = (r_state == S_RESP_D);
    busy    = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      r_streak  <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_grant_d) begin
          mem_we    <= d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          if (!if_req) begin
            r_streak <= '0;
          end else if (r_streak != C_STREAK_MAX) begin
            r_streak <= r_streak + 1'b1;
          end
        end else if (w_grant_if) begin
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          r_streak  <= '0;
        end
      end
      if ((r_state == S_BUSY_IF) && mem_ready) begin
        if_rdata <= mem_rdata;
      end
      // Stores complete without disturbing the last load result.
      if ((r_state == S_BUSY_D) && mem_ready && !mem_we) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the core's instruction-fetch port and its load/store data port.
- Each requester uses a req/ack handshake. The arbiter issues one memory transaction at a time and waits on a variable-latency `mem_ready`.
- Data accesses have priority; a streak counter guarantees fetch forward progress.
- Sits between the core's fetch/LSU stages and the shared RAM, replacing separate instruction ROM and data RAM.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits before fetch is forced to win (≥1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- if_req  input  1  fetch request; held until if_ack.
- if_addr  input  ADDR_W  fetch address; stable while if_req=1.
- if_rdata  output  DATA_W  fetched word; valid in the if_ack cycle, held until the next fetch ack.
- if_ack  output  1  one-cycle fetch completion pulse.
- d_req  input  1  data request; held until d_ack.
- d_we  input  1  1=store, 0=load; stable while d_req=1.
- d_addr  input  ADDR_W  data address; stable while d_req=1.
- d_wdata  input  DATA_W  store data; stable while d_req=1.
- d_rdata  output  DATA_W  load data; valid in the d_ack cycle, held otherwise.
- d_ack  output  1  one-cycle data completion pulse.
- mem_req  output  1  memory transaction active.
- mem_we  output  1  memory write enable; qualified by mem_req.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; valid when mem_ready=1.
- mem_ready  input  1  memory completes the current transaction this cycle.
- busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-high; every register clears immediately on reset assertion.
- Reset values: all outputs 0, state=IDLE, streak=0.
- States: IDLE, BUSY_IF, BUSY_D, RESP_IF, RESP_D.
- IDLE: samples if_req and d_req.
  - Neither asserted: stay in IDLE.
  - Only one asserted: grant that requester.
  - Both asserted: grant data, unless streak==STARVE_MAX, in which case grant fetch.
- On grant: register addr, we and wdata of the winner into mem_addr/mem_we/mem_wdata. Next state is BUSY_x with mem_req=1 from the next cycle.
- Fetch grants always drive mem_we=0 and mem_wdata=0.
- BUSY_x:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and stable.
  - When mem_ready=1: capture mem_rdata into x_rdata (loads and fetches only; a store leaves d_rdata unchanged), go to RESP_x, drop mem_req.
  - When mem_ready=0: stay in BUSY_x with no timeout.
- RESP_x: x_ack=1 for exactly this cycle, then IDLE.
  - The requester must deassert req in the following cycle, or present a new request.
  - The arbiter does not sample requests in RESP_x, so there is no double grant.
- Latency:
  - Minimum 3 cycles from a req seen in IDLE to IDLE again: grant edge, 1 cycle BUSY with zero-wait mem_ready, 1 cycle RESP.
  - ack occurs 2 cycles after the request is sampled, plus memory wait cycles.
- Streak counter, width clog2(STARVE_MAX+1):
  - Increments (saturating) on a data grant when if_req=1 at that grant.
  - Clears on any fetch grant.
  - Clears on a data grant with if_req=0.
- mem_ready while in IDLE or RESP_x is ignored.
- Reset mid-transaction:
  - Abandons the access; mem_req drops asynchronously.
  - No ack is issued.
  - Late mem_ready after reset is ignored.
- Changing req, addr or data while in BUSY_x has no effect; the transaction uses the latched values.

Test Plan:
- Zero-wait fetch: if_req=1, if_addr=0x10, mem_ready=1 in the first BUSY cycle, mem_rdata=0x00500093.
  - Required: mem_req=1 with mem_addr=0x10, mem_we=0 in cycle 1.
  - Required: if_ack=1 and if_rdata=0x00500093 in cycle 2; IDLE in cycle 3.
- Wait-state store: d_req=1, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, mem_ready delayed 3 cycles.
  - Required: mem_req held 4 cycles with mem_we=1 and the latched payload.
  - Required: d_ack pulses once; d_rdata unchanged.
- Simultaneous requests: both requesting with streak=0.
  - Required: data is served first, then fetch.
  - Required: d_ack precedes if_ack by 3 cycles with zero-wait memory.
- Starvation (STARVE_MAX=4): if_req and d_req both held continuously, d_req re-raised immediately after each ack.
  - Required: exactly 4 data grants, then 1 fetch grant, then the streak restarts.
- Reset during BUSY_D: assert reset mid-wait, then pulse mem_ready after release.
  - Required: mem_req=0 immediately, no d_ack, all outputs 0, state IDLE.
- Ignore stray ready: mem_ready=1 while in IDLE with no requests.
  - Required: no ack, if_rdata/d_rdata unchanged, busy=0.
